// File: rtl/swd_phy_engine.sv
// rtl/swd_phy_engine.sv - SWD host PHY engine; WAIT auto-retry enabled by defining SWD_WAIT_RETRY_EN
module swd_phy_engine #(
  parameter int TURN      = 1,
  parameter int DIV_W     = 8,
  parameter int RETRY_MAX = 15
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DIV_W-1:0] CLKDIV,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_APnDP,
  input  logic             REQ_RnW,
  input  logic [1:0]       REQ_ADDR,
  input  logic [31:0]      REQ_WDATA,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [2:0]       RSP_ACK,
  output logic [31:0]      RSP_RDATA,
  output logic             RSP_PERR,
  output logic             SWDCLK,
  input  logic             SWDIN,
  output logic             SWDOUT,
  output logic             SWDOE,
  output logic             BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_TRN1, S_ACK, S_RDATA, S_TRN2, S_WDATA, S_DONE
  } state_t;

  state_t           state, next_state;
  logic             apndp_q, rnw_q;
  logic [1:0]       addr_q;
  logic [31:0]      wdata_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] hcnt;
  logic             phase;
  logic [5:0]       bitcnt;
  logic             active, bit_end, last_bit, accept, retry_go;
  logic [2:0]       ack_now;
  logic [7:0]       hdr;

  // Bit clock runs only while a transfer is on the wire (not IDLE/DONE)
  assign active  = (state != S_IDLE) && (state != S_DONE);
  assign bit_end = active && phase && (hcnt == div_q);
  assign accept  = (state == S_IDLE) && REQ_VALID;
  // Third ACK bit arrives on SWDIN in the same cycle the branch is decided
  assign ack_now = {SWDIN, RSP_ACK[1:0]};
  // Header, first bit in [0]: start, APnDP, RnW, A2, A3, parity, stop, park
  assign hdr = {1'b1, 1'b0, apndp_q ^ rnw_q ^ addr_q[0] ^ addr_q[1],
                addr_q[1], addr_q[0], rnw_q, apndp_q, 1'b1};

`ifdef SWD_WAIT_RETRY_EN
  localparam int RC_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  logic [RC_W-1:0] retry_cnt;

  assign retry_go = (RSP_ACK == 3'b010) && (retry_cnt < RC_W'(RETRY_MAX));

  // Retry budget restarts with every accepted request
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                                retry_cnt <= '0;
    else if (accept)                                          retry_cnt <= '0;
    else if (bit_end && state == S_TRN2 && next_state == S_REQ) retry_cnt <= retry_cnt + 1'b1;
  end
`else
  assign retry_go = 1'b0;
`endif

  // Last bit index of each wire phase
  always_comb begin
    last_bit = 1'b0;
    case (state)
      S_REQ:           last_bit = (bitcnt == 6'd7);
      S_TRN1, S_TRN2:  last_bit = (bitcnt == 6'(TURN - 1));
      S_ACK:           last_bit = (bitcnt == 6'd2);
      S_RDATA, S_WDATA: last_bit = (bitcnt == 6'd32);
      default:         last_bit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state: phases advance only on the last bit's end
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (REQ_VALID) next_state = S_REQ;
      S_REQ:   if (bit_end && last_bit) next_state = S_TRN1;
      S_TRN1:  if (bit_end && last_bit) next_state = S_ACK;
      S_ACK:   if (bit_end && last_bit)
                 next_state = (ack_now == 3'b001 && rnw_q) ? S_RDATA : S_TRN2;
      S_RDATA: if (bit_end && last_bit) next_state = S_TRN2;
      S_TRN2:  if (bit_end && last_bit) begin
                 if (RSP_ACK == 3'b001 && !rnw_q) next_state = S_WDATA;
                 else if (retry_go)               next_state = S_REQ;
                 else                             next_state = S_DONE;
               end
      S_WDATA: if (bit_end && last_bit) next_state = S_DONE;
      S_DONE:  if (RSP_READY) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs; wire drive depends only on state/bitcnt, so it moves only at bit boundaries
  always_comb begin
    SWDCLK    = phase;
    SWDOE     = 1'b1;
    SWDOUT    = 1'b0;
    REQ_READY = (state == S_IDLE) && !RESET;
    RSP_VALID = (state == S_DONE);
    BUSY      = (state != S_IDLE);
    case (state)
      S_REQ:   SWDOUT = hdr[bitcnt[2:0]];
      S_TRN1, S_ACK, S_RDATA, S_TRN2: SWDOE = 1'b0;
      S_WDATA: SWDOUT = bitcnt[5] ? ^wdata_q : wdata_q[bitcnt[4:0]];
      default: SWDOUT = 1'b0;
    endcase
  end

  // Half-period divider: SWDCLK low for the first half of a bit, high for the second
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hcnt  <= '0;
      phase <= 1'b0;
    end else if (!active) begin
      hcnt  <= '0;
      phase <= 1'b0;
    end else if (hcnt == div_q) begin
      hcnt  <= '0;
      phase <= ~phase;
    end else begin
      hcnt  <= hcnt + 1'b1;
    end
  end

  // Request latch, bit counter and response capture (sampled on the SWDCLK falling edge)
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      apndp_q   <= 1'b0;
      rnw_q     <= 1'b0;
      addr_q    <= 2'b00;
      wdata_q   <= '0;
      div_q     <= '0;
      bitcnt    <= '0;
      RSP_ACK   <= 3'b000;
      RSP_RDATA <= '0;
      RSP_PERR  <= 1'b0;
    end else if (accept) begin
      apndp_q   <= REQ_APnDP;
      rnw_q     <= REQ_RnW;
      addr_q    <= REQ_ADDR;
      wdata_q   <= REQ_WDATA;
      div_q     <= CLKDIV;
      bitcnt    <= '0;
      RSP_ACK   <= 3'b000;
      RSP_RDATA <= '0;
      RSP_PERR  <= 1'b0;
    end else if (bit_end) begin
      bitcnt <= (next_state != state) ? 6'd0 : bitcnt + 6'd1;
      if (state == S_ACK) RSP_ACK[bitcnt[1:0]] <= SWDIN;
      if (state == S_RDATA) begin
        if (bitcnt[5]) RSP_PERR <= SWDIN ^ (^RSP_RDATA);
        else           RSP_RDATA[bitcnt[4:0]] <= SWDIN;
      end
    end
  end

endmodule

// File: tb/tb_swd_phy_engine.sv
// tb/tb_swd_phy_engine.sv - directed + random bench for swd_phy_engine with a bit-level SWD target model
module tb_swd_phy_engine;
  localparam int TURN     = 1;
  localparam int DIV_W    = 8;
  localparam int TB_RETRY = 2;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [DIV_W-1:0] CLKDIV = '0;
  logic             REQ_VALID = 1'b0;
  logic             REQ_READY;
  logic             REQ_APnDP = 1'b0;
  logic             REQ_RnW = 1'b0;
  logic [1:0]       REQ_ADDR = 2'b00;
  logic [31:0]      REQ_WDATA = '0;
  logic             RSP_VALID;
  logic             RSP_READY = 1'b0;
  logic [2:0]       RSP_ACK;
  logic [31:0]      RSP_RDATA;
  logic             RSP_PERR;
  logic             SWDCLK;
  logic             SWDIN = 1'b0;
  logic             SWDOUT;
  logic             SWDOE;
  logic             BUSY;

  swd_phy_engine #(.TURN(TURN), .DIV_W(DIV_W), .RETRY_MAX(TB_RETRY)) dut (
    .CLK(CLK), .RESET(RESET), .CLKDIV(CLKDIV),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_APnDP(REQ_APnDP),
    .REQ_RnW(REQ_RnW), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ACK(RSP_ACK),
    .RSP_RDATA(RSP_RDATA), .RSP_PERR(RSP_PERR),
    .SWDCLK(SWDCLK), .SWDIN(SWDIN), .SWDOUT(SWDOUT), .SWDOE(SWDOE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  int          nbits, bad_period, oe_bad, rv_bad, hdr_count, exp_period;
  longint      prev_rise;
  logic [7:0]  last_hdr;
  logic [32:0] last_wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic resync();
    REQ_VALID = 1'b0; RSP_READY = 1'b0; SWDIN = 1'b0; RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  // Wait for the next SWDCLK rise, sample host drive, then present target data for this bit
  task automatic next_bit(input logic din, output logic o, output logic oe, output bit ok);
    int n;
    ok = 1'b0; n = 0; o = 1'b0; oe = 1'b0;
    while (SWDCLK !== 1'b0 && n < 300) begin @(negedge CLK); n++; if (RSP_VALID) rv_bad++; end
    while (SWDCLK !== 1'b1 && n < 300) begin @(negedge CLK); n++; if (RSP_VALID) rv_bad++; end
    if (SWDCLK === 1'b1) begin
      ok = 1'b1;
      o  = SWDOUT;
      oe = SWDOE;
      SWDIN = din;
      if (nbits > 0 && (cyc - prev_rise) != longint'(exp_period)) bad_period++;
      prev_rise = cyc;
      nbits++;
    end else begin
      check("bit_timeout", ok, 1'b1);
    end
  endtask

  task automatic turn_bits(output bit ok);
    logic o, oe;
    ok = 1'b1;
    for (int t = 0; t < TURN; t++) begin
      next_bit(1'b0, o, oe, ok);
      if (!ok) return;
      if (oe !== 1'b0) oe_bad++;
    end
  endtask

  task automatic txn(input logic apndp, input logic rnw, input logic [1:0] addr,
                     input logic [31:0] wdata, input logic [7:0] div, input int n_wait,
                     input logic [2:0] fin_ack, input logic [31:0] rdata, input bit flip,
                     input int rst_bit);
    int          attempts, exp_bits, n, extra;
    logic [2:0]  ack, last_ack;
    logic [7:0]  hdr_got, hdr_oe, hdr_exp;
    logic [32:0] wr_got, wr_oe;
    logic [31:0] exp_rdata;
    logic        exp_perr, o, oe, pc;
    bit          ok;
    // Reference: number of attempts, final ACK and expected wire length
`ifdef SWD_WAIT_RETRY_EN
    attempts = ((n_wait > TB_RETRY) ? TB_RETRY : n_wait) + 1;
`else
    attempts = 1;
`endif
    last_ack  = (attempts - 1 < n_wait) ? 3'b010 : fin_ack;
    exp_rdata = (last_ack == 3'b001 && rnw) ? rdata : 32'h0;
    exp_perr  = (last_ack == 3'b001) && rnw && flip;
    exp_bits  = 0;
    for (int a = 0; a < attempts; a++)
      exp_bits += 8 + TURN + 3 + TURN + ((((a < n_wait) ? 3'b010 : fin_ack) == 3'b001) ? 33 : 0);
    hdr_exp = {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1], addr[1], addr[0], rnw, apndp, 1'b1};

    nbits = 0; bad_period = 0; oe_bad = 0; rv_bad = 0; hdr_count = 0; prev_rise = 0;
    exp_period = 2 * (int'(div) + 1);
    wr_got = '0;

    @(negedge CLK);
    REQ_APnDP = apndp; REQ_RnW = rnw; REQ_ADDR = addr; REQ_WDATA = wdata; CLKDIV = div;
    REQ_VALID = 1'b1;
    n = 0;
    while (REQ_READY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    check("req_ready", REQ_READY, 1'b1);
    if (REQ_READY !== 1'b1) begin resync(); return; end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    CLKDIV = DIV_W'($urandom);
    REQ_WDATA = $urandom; REQ_ADDR = 2'($urandom); REQ_RnW = ~rnw;
    check("busy_after_accept", {BUSY, REQ_READY}, 2'b10);

    for (int a = 0; a < attempts; a++) begin
      ack = (a < n_wait) ? 3'b010 : fin_ack;
      for (int i = 0; i < 8; i++) begin
        next_bit(1'b0, o, oe, ok);
        if (!ok) begin resync(); return; end
        hdr_got[i] = o; hdr_oe[i] = oe;
      end
      check($sformatf("header%0d", a), hdr_got, hdr_exp);
      check("header_oe", hdr_oe, 8'hFF);
      if (hdr_got[0] && hdr_got[7]) hdr_count++;
      last_hdr = hdr_got;
      turn_bits(ok);
      if (!ok) begin resync(); return; end
      for (int k = 0; k < 3; k++) begin
        next_bit(ack[k], o, oe, ok);
        if (!ok) begin resync(); return; end
        if (oe !== 1'b0) oe_bad++;
      end
      if (ack == 3'b001 && rnw) begin
        for (int k = 0; k < 33; k++) begin
          next_bit((k < 32) ? rdata[k] : ((^rdata) ^ flip), o, oe, ok);
          if (!ok) begin resync(); return; end
          if (oe !== 1'b0) oe_bad++;
          if (k == rst_bit) begin
            RESET = 1'b1; #1;
            check("rst_async_pins", {SWDCLK, SWDOE, SWDOUT, REQ_READY, RSP_VALID, BUSY}, 6'b010000);
            check("rst_async_rsp", {RSP_ACK, RSP_PERR, RSP_RDATA}, 36'h0);
            repeat (2) @(negedge CLK);
            RESET = 1'b0; #1;
            check("rst_release_ready", {REQ_READY, BUSY}, 2'b10);
            n = 0;
            repeat (20) begin @(negedge CLK); if (RSP_VALID) n++; end
            check("rst_no_response", n, 0);
            return;
          end
        end
        turn_bits(ok);
        if (!ok) begin resync(); return; end
      end else if (ack == 3'b001) begin
        turn_bits(ok);
        if (!ok) begin resync(); return; end
        for (int k = 0; k < 33; k++) begin
          next_bit(1'b0, o, oe, ok);
          if (!ok) begin resync(); return; end
          wr_got[k] = o; wr_oe[k] = oe;
        end
        check("wdata_bits", wr_got, {^wdata, wdata});
        check("wdata_oe", wr_oe, {33{1'b1}});
        last_wr = wr_got;
      end else begin
        turn_bits(ok);
        if (!ok) begin resync(); return; end
      end
    end

    n = 0; extra = 0; pc = SWDCLK;
    while (RSP_VALID !== 1'b1 && n < 60) begin
      @(negedge CLK); n++;
      if (SWDCLK && !pc) extra++;
      pc = SWDCLK;
    end
    check("rsp_valid", RSP_VALID, 1'b1);
    if (RSP_VALID !== 1'b1) begin resync(); return; end
    check("extra_bits", extra, 0);
    check("bit_count", nbits, exp_bits);
    check("bit_period", bad_period, 0);
    check("turn_oe_low", oe_bad, 0);
    check("no_early_rsp", rv_bad, 0);
    check("rsp_ack", RSP_ACK, last_ack);
    check("rsp_rdata", RSP_RDATA, exp_rdata);
    check("rsp_perr", RSP_PERR, exp_perr);
    check("done_pins", {SWDCLK, SWDOE, SWDOUT, REQ_READY, BUSY}, 5'b01001);
    repeat ($urandom_range(1, 3)) @(negedge CLK);
    check("rsp_hold", {RSP_VALID, RSP_ACK, RSP_PERR, RSP_RDATA}, {1'b1, last_ack, exp_perr, exp_rdata});
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    check("rsp_release", {RSP_VALID, REQ_READY, BUSY}, 3'b010);
  endtask

  logic [2:0] ack_tab [5];

  initial begin
    int exp_hdrs;
    ack_tab[0] = 3'b001; ack_tab[1] = 3'b001; ack_tab[2] = 3'b010;
    ack_tab[3] = 3'b100; ack_tab[4] = 3'b111;

    repeat (3) @(negedge CLK);
    check("reset_pins", {SWDCLK, SWDOE, SWDOUT, REQ_READY, RSP_VALID, BUSY}, 6'b010000);
    check("reset_rsp", {RSP_ACK, RSP_PERR, RSP_RDATA}, 36'h0);
    RESET = 1'b0; #1;
    check("ready_after_reset", REQ_READY, 1'b1);

    // IDCODE read at CLKDIV=0
    txn(1'b0, 1'b1, 2'b00, 32'h0, 8'd0, 0, 3'b001, 32'h2BA01477, 1'b0, -1);
    check("idcode_header", last_hdr, 8'b10100101);
    check("idcode_swdclk_periods", nbits, 46);

    // AP write A=1 at CLKDIV=3
    txn(1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 8'd3, 0, 3'b001, 32'h0, 1'b0, -1);
    check("write_parity_bit", last_wr[32], 1'b0);

    // Read with corrupted parity
    txn(1'b0, 1'b1, 2'b11, 32'h0, 8'd1, 0, 3'b001, 32'h00000001, 1'b1, -1);

    // FAULT: no data phase
    txn(1'b1, 1'b1, 2'b00, 32'h0, 8'd2, 0, 3'b100, 32'hFFFFFFFF, 1'b0, -1);
    check("fault_bits", nbits, 8 + TURN + 3 + TURN);

    // WAIT three times
    txn(1'b1, 1'b1, 2'b10, 32'h0, 8'd0, 3, 3'b001, 32'h12345678, 1'b0, -1);
`ifdef SWD_WAIT_RETRY_EN
    exp_hdrs = TB_RETRY + 1;
`else
    exp_hdrs = 1;
`endif
    check("wait_header_count", hdr_count, exp_hdrs);

    // Reset during RDATA bit 10, then a normal transaction
    txn(1'b0, 1'b1, 2'b01, 32'h0, 8'd1, 0, 3'b001, $urandom, 1'b0, 10);
    txn(1'b0, 1'b1, 2'b01, 32'h0, 8'd1, 0, 3'b001, 32'hA5C3_0F96, 1'b0, -1);

    // Randomized transactions
    for (int r = 0; r < 12; r++) begin
      txn(1'($urandom), 1'($urandom), 2'($urandom), $urandom, 8'($urandom_range(0, 3)),
          $urandom_range(0, 3), ack_tab[$urandom_range(0, 4)], $urandom,
          ($urandom_range(0, 3) == 0), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
